// File: rtl/freq_meter_pkg.sv
// Shared constants and FSM state type for the frequency meter and the clock generator.
// f = STEP*code + F_MIN; GATE_SCALE is the Hz weight of one edge at the default gate.
package freq_pkg;

  localparam int unsigned F_MIN      = 6000;
  localparam int unsigned F_MAX      = 800000;
  localparam int unsigned STEP       = (F_MAX - F_MIN) / 255;
  localparam int unsigned GATE_SCALE = 100;
  localparam int unsigned CODE_W     = 8;
  localparam int unsigned HZ_W       = 25;
  localparam int unsigned DIV_W      = 20;
  localparam int unsigned DIVISOR_W  = 12;
  localparam int unsigned EDGE_W     = 18;

  typedef enum logic [1:0] {
    COUNT,
    SCALE,
    DIVIDE,
    PUBLISH
  } meter_state_t;

endpackage

// File: rtl/freq_meter_divider.sv
// Restoring divider, 20-bit dividend by 12-bit divisor, one quotient bit per cycle.
// The start cycle performs the first step, so done pulses 20 cycles after start.
module code_divider
  import freq_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic [DIV_W-1:0]     dividend,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0] remainder
);

  logic [4:0]                  iter_left;
  logic [DIVISOR_W-1:0]        divisor_q;
  logic [DIVISOR_W+DIV_W-1:0]  step_res;

  function automatic logic [DIVISOR_W+DIV_W-1:0] div_step(
    input logic [DIVISOR_W-1:0] rem,
    input logic [DIV_W-1:0]     quo,
    input logic [DIVISOR_W-1:0] dvs
  );
    logic [DIVISOR_W:0] trial;
    logic [DIVISOR_W:0] diff;
    trial = {rem, quo[DIV_W-1]};
    diff  = trial - {1'b0, dvs};
    if (trial >= {1'b0, dvs})
      return {diff[DIVISOR_W-1:0], quo[DIV_W-2:0], 1'b1};
    return {trial[DIVISOR_W-1:0], quo[DIV_W-2:0], 1'b0};
  endfunction

  always_comb begin
    step_res = '0;
    if (busy)
      step_res = div_step(remainder, quotient, divisor_q);
    else
      step_res = div_step('0, dividend, divisor);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      iter_left <= '0;
      divisor_q <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          divisor_q               <= divisor;
          {remainder, quotient}   <= step_res;
          iter_left               <= 5'(DIV_W - 1);
          busy                    <= 1'b1;
        end
      end else begin
        {remainder, quotient} <= step_res;
        iter_left             <= iter_left - 5'd1;
        if (iter_left == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter plus Hz-to-code conversion (code = (hz - F_MIN) / STEP).
// Define FREQ_METER_GLITCH_FILTER_EN to add a 3-tap majority filter on the input.
module freq_meter
  import freq_pkg::*;
#(
  parameter int unsigned F_CLK       = 50000000,
  parameter int unsigned GATE_CYCLES = 500000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sig_in,
  output logic [HZ_W-1:0]   freq_hz,
  output logic [CODE_W-1:0] freq_code,
  output logic              under_range,
  output logic              over_range,
  output logic              meas_valid
);

  localparam int unsigned SCALE_HZ = F_CLK / GATE_CYCLES;
  localparam int unsigned GATE_W   = $clog2(GATE_CYCLES);
  localparam int unsigned PROD_W   = EDGE_W + HZ_W;

  logic sync_meta, sync_sig, sig_clean, sig_prev, rise;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_meta <= 1'b0;
      sync_sig  <= 1'b0;
    end else begin
      sync_meta <= sig_in;
      sync_sig  <= sync_meta;
    end
  end

`ifdef FREQ_METER_GLITCH_FILTER_EN
  logic tap1, tap2;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tap1      <= 1'b0;
      tap2      <= 1'b0;
      sig_clean <= 1'b0;
    end else begin
      tap1      <= sync_sig;
      tap2      <= tap1;
      sig_clean <= (sync_sig & tap1) | (sync_sig & tap2) | (tap1 & tap2);
    end
  end
`else
  assign sig_clean = sync_sig;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) sig_prev <= 1'b0;
    else        sig_prev <= sig_clean;
  end

  assign rise = sig_clean & ~sig_prev;

  logic [GATE_W-1:0] gate_cnt;
  logic [EDGE_W-1:0] edge_cnt, latched_cnt;
  logic              wrap;

  assign wrap = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

  // An edge seen on the wrap cycle seeds the new window instead of being lost.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      latched_cnt <= '0;
    end else if (wrap) begin
      gate_cnt    <= '0;
      latched_cnt <= edge_cnt;
      edge_cnt    <= EDGE_W'(rise);
    end else begin
      gate_cnt <= gate_cnt + 1'b1;
      if (rise && (edge_cnt != '1))
        edge_cnt <= edge_cnt + 1'b1;
    end
  end

  logic [PROD_W-1:0] hz_wide;
  logic [HZ_W-1:0]   hz_c, hz_q;
  logic              under_c, over_c, under_q, over_q;

  always_comb begin
    hz_wide = PROD_W'(latched_cnt) * PROD_W'(SCALE_HZ);
    hz_c    = (|hz_wide[PROD_W-1:HZ_W]) ? '1 : hz_wide[HZ_W-1:0];
    under_c = (hz_c < HZ_W'(F_MIN));
    over_c  = (hz_c > HZ_W'(F_MAX));
  end

  logic              div_start, div_busy, div_done;
  logic [DIV_W-1:0]  div_quo;
  logic [DIVISOR_W-1:0] div_rem;

  code_divider u_div (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start     (div_start),
    .dividend  (DIV_W'(hz_c - HZ_W'(F_MIN))),
    .divisor   (DIVISOR_W'(STEP)),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  meter_state_t state, next_state;

  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    unique case (state)
      COUNT:   if (wrap) next_state = SCALE;
      SCALE: begin
        if (under_c || over_c) begin
          next_state = PUBLISH;
        end else if (!div_busy) begin
          div_start  = 1'b1;
          next_state = DIVIDE;
        end
      end
      DIVIDE:  if (div_done) next_state = PUBLISH;
      PUBLISH: next_state = COUNT;
      default: next_state = COUNT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= COUNT;
      hz_q        <= '0;
      under_q     <= 1'b0;
      over_q      <= 1'b0;
      freq_hz     <= '0;
      freq_code   <= '0;
      under_range <= 1'b0;
      over_range  <= 1'b0;
      meas_valid  <= 1'b0;
    end else begin
      state      <= next_state;
      meas_valid <= (state == PUBLISH);
      if (state == SCALE) begin
        hz_q    <= hz_c;
        under_q <= under_c;
        over_q  <= over_c;
      end
      if (state == PUBLISH) begin
        freq_hz     <= hz_q;
        under_range <= under_q;
        over_range  <= over_q;
        if (under_q)
          freq_code <= '0;
        else if (over_q || (div_quo > DIV_W'(255)))
          freq_code <= '1;
        else
          freq_code <= div_quo[CODE_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a shortened gate (GATE_SCALE = 1000 Hz per edge).
// sig_in is a gate-periodic pattern, so every full window holds exactly the requested edges.
module tb_freq_meter;

  localparam int unsigned G      = 2000;
  localparam int unsigned F_CLK  = 2000000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        sig_in = 1'b0;
  logic [24:0] freq_hz;
  logic [7:0]  freq_code;
  logic        under_range, over_range, meas_valid;

  int checks = 0;
  int passed = 0;

  int unsigned stim_edges  = 100;
  logic        stim_level  = 1'b0;
  logic        stim_glitch = 1'b0;

  freq_meter #(.F_CLK(F_CLK), .GATE_CYCLES(G)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .sig_in      (sig_in),
    .freq_hz     (freq_hz),
    .freq_code   (freq_code),
    .under_range (under_range),
    .over_range  (over_range),
    .meas_valid  (meas_valid)
  );

  always #5 clk_in = ~clk_in;

  initial begin : drive_sig
    int unsigned t;
    t = 0;
    forever begin
      @(negedge clk_in);
      t = (t + 1) % G;
      if (stim_edges == 0) begin
        sig_in = stim_level;
      end else begin
        sig_in = (((t * 2 * stim_edges) / G) % 2) == 1;
        if (stim_glitch && (t % 10 == 2)) sig_in = 1'b1;
      end
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic wait_valid(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < 3 * G) begin
      @(negedge clk_in);
      cycles++;
      if (meas_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic measure(input string tag, input int unsigned edges, input logic level,
                         input logic glitch, input int exp_hz, input int exp_code,
                         input logic exp_under, input logic exp_over);
    int cyc;
    bit ok;
    stim_edges  = edges;
    stim_level  = level;
    stim_glitch = glitch;
    wait_valid(cyc, ok);
    check_eq({tag, " settle pulse"}, ok, 1);
    wait_valid(cyc, ok);
    check_eq({tag, " pulse"}, ok, 1);
    if (ok) begin
      check_eq({tag, " period"}, cyc, G);
      check_eq({tag, " hz"}, freq_hz, exp_hz);
      check_eq({tag, " code"}, freq_code, exp_code);
      check_eq({tag, " under"}, under_range, exp_under);
      check_eq({tag, " over"}, over_range, exp_over);
    end
  endtask

  initial begin : main
    int cyc;
    bit ok;
    repeat (3) @(negedge clk_in);
    check_eq("rst hz", freq_hz, 0);
    check_eq("rst code", freq_code, 0);
    check_eq("rst under", under_range, 0);
    check_eq("rst over", over_range, 0);
    check_eq("rst valid", meas_valid, 0);
    rst_in = 1'b0;

    wait_valid(cyc, ok);
    check_eq("first pulse", ok, 1);
    check_eq("first latency", (cyc >= G + 2) && (cyc <= G + 22), 1);

    measure("100k",   100,  1'b0, 1'b0, 100000,  30,  1'b0, 1'b0);
    measure("6k",     6,    1'b0, 1'b0, 6000,    0,   1'b0, 1'b0);
    measure("5k",     5,    1'b0, 1'b0, 5000,    0,   1'b1, 1'b0);
    measure("10k",    10,   1'b0, 1'b0, 10000,   1,   1'b0, 1'b0);
    measure("400k",   400,  1'b0, 1'b0, 400000,  126, 1'b0, 1'b0);
    measure("800k",   800,  1'b0, 1'b0, 800000,  255, 1'b0, 1'b0);
    measure("801k",   801,  1'b0, 1'b0, 801000,  255, 1'b0, 1'b1);
    measure("1M",     1000, 1'b0, 1'b0, 1000000, 255, 1'b0, 1'b1);
    measure("stuck0", 0,    1'b0, 1'b0, 0,       0,   1'b1, 1'b0);
    measure("stuck1", 0,    1'b1, 1'b0, 0,       0,   1'b1, 1'b0);
`ifdef FREQ_METER_GLITCH_FILTER_EN
    measure("200k glitch", 200, 1'b0, 1'b1, 200000, 62, 1'b0, 1'b0);
`else
    measure("200k glitch", 200, 1'b0, 1'b1, 400000, 126, 1'b0, 1'b0);
`endif

    stim_edges  = 100;
    stim_glitch = 1'b0;
    repeat (G / 2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    check_eq("midrst hz", freq_hz, 0);
    check_eq("midrst code", freq_code, 0);
    check_eq("midrst over", over_range, 0);
    check_eq("midrst valid", meas_valid, 0);
    wait_valid(cyc, ok);
    check_eq("midrst pulse", ok, 1);
    check_eq("midrst latency", (cyc >= G + 2) && (cyc <= G + 22), 1);
    wait_valid(cyc, ok);
    check_eq("post rst pulse", ok, 1);
    check_eq("post rst hz", freq_hz, 100000);
    check_eq("post rst code", freq_code, 30);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
